// File: rtl/display_bcd_converter_pkg.sv
// Shared constants and state encoding for the 14-bit binary to 4-digit BCD converter.
package display_bcd_converter_pkg;
  localparam int VALUE_W     = 14;
  localparam int DIGITS      = 4;
  localparam int BCD_W       = 4 * DIGITS;
  localparam int MAX_DISPLAY = 9999;
  localparam int N_ITER      = 14;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/display_bcd_converter_if.sv
// Request/result bundle between a display controller (master) and the converter (slave).
interface display_bcd_converter_if;
  import display_bcd_converter_pkg::*;

  logic               start;
  logic [VALUE_W-1:0] value;
  logic               busy;
  logic               done;
  logic               ovf;
  logic [3:0]         data1;
  logic [3:0]         data2;
  logic [3:0]         data3;
  logic [3:0]         data4;

  modport master (
    output start, value,
    input  busy, done, ovf, data1, data2, data3, data4
  );

  modport slave (
    input  start, value,
    output busy, done, ovf, data1, data2, data3, data4
  );
endinterface

// File: rtl/display_bcd_converter_add3.sv
// Double-dabble nibble correction: add 3 to any BCD nibble of 5 or more before the shift.
module bcd_add3 (
  input  logic [3:0] nibble,
  output logic [3:0] corrected
);
  // nibble correction
  always_comb begin
    if (nibble >= 4'd5) begin
      corrected = nibble + 4'd3;
    end else begin
      corrected = nibble;
    end
  end
endmodule

// File: rtl/display_bcd_converter.sv
// Sequential double-dabble converter: one bit per cycle, results above 9999 saturate to 9999 with ovf.
module display_bcd_converter
  import display_bcd_converter_pkg::*;
(
  input logic                    clk,
  input logic                    rst,
  display_bcd_converter_if.slave bus
);
  state_t             state_r, state_nxt_s;
  logic [VALUE_W-1:0] bin_r;
  logic [BCD_W-1:0]   scratch_r;
  logic [BCD_W-1:0]   corr_s;
  logic [BCD_W-1:0]   data_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               ovf_pend_r;
  logic               busy_r, done_r, ovf_r;
  logic               load_s, shift_s, commit_s, busy_nxt_s;

  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_add3
      bcd_add3 u_add3 (
        .nibble    (scratch_r[4*i +: 4]),
        .corrected (corr_s[4*i +: 4])
      );
    end
  endgenerate

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // next-state logic; start is only looked at in IDLE, so requests while busy are dropped
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (bus.start) state_nxt_s = SHIFT; else state_nxt_s = IDLE;
      SHIFT:   if (cnt_r == {CNT_W{1'b0}}) state_nxt_s = DONE; else state_nxt_s = SHIFT;
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // per-state datapath controls
  always_comb begin
    load_s     = 1'b0;
    shift_s    = 1'b0;
    commit_s   = 1'b0;
    busy_nxt_s = (state_nxt_s != IDLE);
    case (state_r)
      IDLE:    load_s   = bus.start;
      SHIFT:   shift_s  = 1'b1;
      DONE:    commit_s = 1'b1;
      default: load_s   = 1'b0;
    endcase
  end

  // conversion datapath: capture, then shift {scratch, binary} left once per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_r      <= {VALUE_W{1'b0}};
      scratch_r  <= {BCD_W{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      ovf_pend_r <= 1'b0;
    end else if (load_s) begin
      bin_r      <= bus.value;
      scratch_r  <= {BCD_W{1'b0}};
      cnt_r      <= CNT_W'(N_ITER - 1);
      ovf_pend_r <= (bus.value > VALUE_W'(MAX_DISPLAY));
    end else if (shift_s) begin
      scratch_r <= {corr_s[BCD_W-2:0], bin_r[VALUE_W-1]};
      bin_r     <= {bin_r[VALUE_W-2:0], 1'b0};
      if (cnt_r != {CNT_W{1'b0}}) begin
        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_r <= {CNT_W{1'b0}};
      end
    end else begin
      bin_r <= bin_r;
    end
  end

  // result registers only move on the commit edge, so partial digits never reach the display
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      ovf_r  <= 1'b0;
      data_r <= {BCD_W{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
      done_r <= commit_s;
      if (commit_s) begin
        ovf_r  <= ovf_pend_r;
        data_r <= ovf_pend_r ? 16'h9999 : scratch_r;
      end else begin
        ovf_r  <= ovf_r;
        data_r <= data_r;
      end
    end
  end

  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.ovf   = ovf_r;
  assign bus.data1 = data_r[15:12];
  assign bus.data2 = data_r[11:8];
  assign bus.data3 = data_r[7:4];
  assign bus.data4 = data_r[3:0];
endmodule

// File: tb/tb_display_bcd_converter.sv
// Scoreboard bench: expected digits are queued when a start is accepted and popped on the done cycle.
module tb_display_bcd_converter;
  import display_bcd_converter_pkg::*;

  typedef struct {
    int          done_at;
    logic [15:0] digits;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  display_bcd_converter_if bus ();

  display_bcd_converter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t        sb_q[$];
  int          n_checks  = 0;
  int          n_pass    = 0;
  int          cyc       = 0;
  int          next_free = 0;
  int          busy_last = -1;
  logic [15:0] mdl_data  = 16'h0000;
  logic        mdl_ovf   = 1'b0;

  function automatic logic [15:0] bcd_of(input int v);
    if (v > MAX_DISPLAY) return 16'h9999;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // one clock: drive at negedge, update model for the coming edge, compare at the next negedge
  task automatic step(input logic s, input int v, input logic r);
    exp_t e;
    logic exp_done;
    rst       = r;
    bus.start = s;
    bus.value = 14'(v);
    if (r) begin
      sb_q.delete();
      busy_last = -1;
      next_free = cyc + 2;
      mdl_data  = 16'h0000;
      mdl_ovf   = 1'b0;
    end else if (s && (cyc + 1 >= next_free)) begin
      e.done_at = cyc + 16;
      e.digits  = bcd_of(v);
      e.ovf     = (v > MAX_DISPLAY);
      sb_q.push_back(e);
      next_free = cyc + 17;
      busy_last = cyc + 15;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    exp_done = 1'b0;
    if (sb_q.size() > 0 && sb_q[0].done_at == cyc) begin
      e        = sb_q.pop_front();
      exp_done = 1'b1;
      mdl_data = e.digits;
      mdl_ovf  = e.ovf;
    end
    check("busy_done", {30'd0, bus.busy, bus.done}, {30'd0, (cyc <= busy_last), exp_done});
    check("digits_ovf", {15'd0, bus.ovf, bus.data1, bus.data2, bus.data3, bus.data4},
          {15'd0, mdl_ovf, mdl_data});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0);
  endtask

  task automatic convert(input int v);
    step(1'b1, v, 1'b0);
    idle(17);
  endtask

  initial begin
    int vals[5];
    bus.start = 1'b0;
    bus.value = 14'd0;
    vals = '{0, 9999, 10000, 16383, 42};
    @(negedge clk);
    step(1'b0, 0, 1'b1);
    step(1'b1, 1234, 1'b1);
    idle(2);

    convert(1234);
    foreach (vals[i]) convert(vals[i]);

    // requests while busy are dropped
    step(1'b1, 5678, 1'b0);
    idle(2);
    step(1'b1, 1111, 1'b0);
    idle(6);
    step(1'b1, 1111, 1'b0);
    idle(12);

    // reset aborts a running conversion
    convert(4321);
    step(1'b1, 8765, 1'b0);
    idle(5);
    step(1'b0, 0, 1'b1);
    idle(20);

    // start held high: back-to-back conversions, value changed while busy
    step(1'b1, 307, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 2024, 1'b0);
    idle(18);

    // reset wins over a simultaneous start
    step(1'b1, 1234, 1'b1);
    idle(3);

    for (int i = 0; i < 6; i++) begin
      step(1'b1, int'($urandom_range(0, 16383)), 1'b0);
      idle(int'($urandom_range(15, 19)));
    end
    idle(18);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
